// File: rtl/enemy_chaser_if.sv
// Bundles the chef/map inputs and enemy outputs exchanged between the game top and one enemy.
interface enemy_chaser_if;
  logic       enable;
  logic [9:0] ChefX;
  logic [9:0] ChefY;
  logic       walk;
  logic       climb;
  logic       squash;
  logic [9:0] EnemyX;
  logic [9:0] EnemyY;
  logic       hurt_chef;
  logic       squashed;
  logic       alive;

  modport master (
    output enable, ChefX, ChefY, walk, climb, squash,
    input  EnemyX, EnemyY, hurt_chef, squashed, alive
  );

  modport slave (
    input  enable, ChefX, ChefY, walk, climb, squash,
    output EnemyX, EnemyY, hurt_chef, squashed, alive
  );
endinterface

// File: rtl/enemy_chaser.sv
// One pursuing enemy: steps toward the chef at frame rate, flags contact and squash,
// and sits out a respawn delay after either event.
module enemy_chaser #(
  parameter int SPAWN_X        = 8,
  parameter int SPAWN_Y        = 148,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 192,
  parameter int Y_MIN          = 5,
  parameter int Y_MAX          = 148,
  parameter int STEP_DIV       = 3,
  parameter int HIT_RADIUS     = 4,
  parameter int RESPAWN_FRAMES = 120
) (
  input logic            frame_clk,
  input logic            Reset_n,
  enemy_chaser_if.slave  bus
);

  localparam int TIMER_W = $clog2(RESPAWN_FRAMES + 1);
  localparam int STEP_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [9:0]         XMIN      = 10'(X_MIN);
  localparam logic [9:0]         XMAX      = 10'(X_MAX);
  localparam logic [9:0]         YMIN      = 10'(Y_MIN);
  localparam logic [9:0]         YMAX      = 10'(Y_MAX);
  localparam logic [9:0]         SPX       = 10'(SPAWN_X);
  localparam logic [9:0]         SPY       = 10'(SPAWN_Y);
  localparam logic [9:0]         RADIUS    = 10'(HIT_RADIUS);
  localparam logic [TIMER_W-1:0] TIMER_TOP = TIMER_W'(RESPAWN_FRAMES);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {RESPAWN, CHASE, HIT} state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [STEP_W-1:0]  step_cnt, step_next;
  logic [9:0]         enemy_x, enemy_y, x_next, y_next;
  logic               hurt_q, squashed_q, alive_q;
  logic               hurt_next, squashed_next;
  logic [9:0]         dx, dy;
  logic               contact;

  // Magnitudes taken as larger minus smaller so the unsigned difference never wraps.
  assign dx      = (bus.ChefX > enemy_x) ? (bus.ChefX - enemy_x) : (enemy_x - bus.ChefX);
  assign dy      = (bus.ChefY > enemy_y) ? (bus.ChefY - enemy_y) : (enemy_y - bus.ChefY);
  assign contact = (dx < RADIUS) && (dy < RADIUS);

  always_comb begin
    state_next    = state;
    timer_next    = timer;
    step_next     = step_cnt;
    x_next        = enemy_x;
    y_next        = enemy_y;
    hurt_next     = 1'b0;
    squashed_next = 1'b0;
    if (bus.enable) begin
      case (state)
        RESPAWN: begin
          if (timer == '0) begin
            state_next = CHASE;
            step_next  = '0;
          end else begin
            timer_next = timer - TIMER_W'(1);
          end
        end
        CHASE: begin
          if (bus.squash) begin
            squashed_next = 1'b1;
            state_next    = RESPAWN;
            timer_next    = TIMER_TOP;
            step_next     = '0;
            x_next        = SPX;
            y_next        = SPY;
          end else if (contact) begin
            hurt_next  = 1'b1;
            state_next = HIT;
          end else if (step_cnt != STEP_LAST) begin
            step_next = step_cnt + STEP_W'(1);
          end else begin
            // Ladder motion wins over walking; with no legal surface the enemy drops.
            step_next = '0;
            if (bus.climb && (bus.ChefY != enemy_y)) begin
              if (bus.ChefY > enemy_y) begin
                if (enemy_y < YMAX) y_next = enemy_y + 10'd1;
              end else begin
                if (enemy_y > YMIN) y_next = enemy_y - 10'd1;
              end
            end else if (bus.walk && (bus.ChefX != enemy_x)) begin
              if (bus.ChefX > enemy_x) begin
                if (enemy_x < XMAX) x_next = enemy_x + 10'd1;
              end else begin
                if (enemy_x > XMIN) x_next = enemy_x - 10'd1;
              end
            end else if (!bus.walk && !bus.climb) begin
              if (enemy_y < YMAX) y_next = enemy_y + 10'd1;
            end
          end
        end
        HIT: begin
          state_next = RESPAWN;
          timer_next = TIMER_TOP;
          step_next  = '0;
          x_next     = SPX;
          y_next     = SPY;
        end
        default: begin
          state_next = RESPAWN;
          timer_next = TIMER_TOP;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state      <= RESPAWN;
      timer      <= TIMER_TOP;
      step_cnt   <= '0;
      enemy_x    <= SPX;
      enemy_y    <= SPY;
      hurt_q     <= 1'b0;
      squashed_q <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      step_cnt   <= step_next;
      enemy_x    <= x_next;
      enemy_y    <= y_next;
      hurt_q     <= hurt_next;
      squashed_q <= squashed_next;
      alive_q    <= (state_next == CHASE);
    end
  end

  assign bus.EnemyX    = enemy_x;
  assign bus.EnemyY    = enemy_y;
  assign bus.hurt_chef = hurt_q;
  assign bus.squashed  = squashed_q;
  assign bus.alive     = alive_q;

endmodule
